// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-style port between the instruction fetch and data access
// masters. Data wins arbitration unless the fetch port has been starved.
module mem_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_read_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_data_o,
  output logic        inst_stall_o,
  input  logic        data_read_i,
  input  logic        data_write_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_mask_i,
  output logic [31:0] data_rdata_o,
  output logic        data_stall_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_sel_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int unsigned STV_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [STV_W-1:0]   r_starve, w_starve_nxt;
  logic               r_gnt_data, w_gnt_data_nxt;
  logic               r_ce, w_ce_nxt;
  logic               r_we, w_we_nxt;
  logic [31:0]        r_addr, w_addr_nxt;
  logic [31:0]        r_wdata, w_wdata_nxt;
  logic [3:0]         r_sel, w_sel_nxt;
  logic [31:0]        r_inst_data, w_inst_data_nxt;
  logic [31:0]        r_data_rdata, w_data_rdata_nxt;
  logic               w_data_req;
  logic               w_starved;

  assign w_data_req = data_read_i | data_write_i;
  assign w_starved  = inst_read_i && (r_starve == STV_W'(STARVE_LIMIT));

  // Next-state, grant decision and next values of all registered outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_starve_nxt     = r_starve;
    w_gnt_data_nxt   = r_gnt_data;
    w_ce_nxt         = r_ce;
    w_we_nxt         = r_we;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_sel_nxt        = r_sel;
    w_inst_data_nxt  = r_inst_data;
    w_data_rdata_nxt = r_data_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_data_req && !w_starved) begin
          w_state_nxt    = S_ACCESS;
          w_cnt_nxt      = CNT_W'(WAIT_CYCLES);
          w_gnt_data_nxt = 1'b1;
          w_ce_nxt       = 1'b1;
          w_we_nxt       = data_write_i;
          w_addr_nxt     = data_addr_i;
          w_wdata_nxt    = data_wdata_i;
          w_sel_nxt      = data_mask_i;
          if (!inst_read_i) begin
            w_starve_nxt = '0;
          end else if (r_starve != STV_W'(STARVE_LIMIT)) begin
            w_starve_nxt = r_starve + STV_W'(1);
          end
        end else if (inst_read_i) begin
          w_state_nxt    = S_ACCESS;
          w_cnt_nxt      = CNT_W'(WAIT_CYCLES);
          w_gnt_data_nxt = 1'b0;
          w_ce_nxt       = 1'b1;
          w_we_nxt       = 1'b0;
          w_addr_nxt     = inst_addr_i;
          w_wdata_nxt    = '0;
          w_sel_nxt      = 4'b1111;
          w_starve_nxt   = '0;
        end
      end
      S_ACCESS: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_DONE;
          w_ce_nxt    = 1'b0;
          w_we_nxt    = 1'b0;
          if (!r_we) begin
            if (r_gnt_data) begin
              w_data_rdata_nxt = mem_rdata_i;
            end else begin
              w_inst_data_nxt = mem_rdata_i;
            end
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_starve     <= '0;
      r_gnt_data   <= 1'b0;
      r_ce         <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_sel        <= '0;
      r_inst_data  <= '0;
      r_data_rdata <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_starve     <= w_starve_nxt;
      r_gnt_data   <= w_gnt_data_nxt;
      r_ce         <= w_ce_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_sel        <= w_sel_nxt;
      r_inst_data  <= w_inst_data_nxt;
      r_data_rdata <= w_data_rdata_nxt;
    end
  end

  // A master is released only in the DONE cycle of its own access.
  assign inst_stall_o = inst_read_i & ~(~r_gnt_data & (r_state == S_DONE));
  assign data_stall_o = w_data_req  & ~( r_gnt_data & (r_state == S_DONE));

  assign inst_data_o  = r_inst_data;
  assign data_rdata_o = r_data_rdata;
  assign mem_ce_o     = r_ce;
  assign mem_we_o     = r_we;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign mem_sel_o    = r_sel;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios on a
// WAIT_CYCLES=1 and a WAIT_CYCLES=3 instance plus randomized traffic
// against a transaction-timing reference model.
module tb_mem_bus_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir, dr, dw;
  logic [31:0] ia, da, dwd;
  logic [3:0]  dm;

  logic [31:0] o1_idata, o1_ddata, o1_addr, o1_wdata, rd1;
  logic        o1_istall, o1_dstall, o1_ce, o1_we;
  logic [3:0]  o1_sel;
  logic [31:0] o3_idata, o3_ddata, o3_addr, o3_wdata, rd3;
  logic        o3_istall, o3_dstall, o3_ce, o3_we;
  logic [3:0]  o3_sel;

  int sel = 0;
  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ob_idata, ob_ddata, ob_addr, ob_wdata;
  logic        ob_istall, ob_dstall, ob_ce, ob_we;
  logic [3:0]  ob_sel;

  always #5 clk = ~clk;

  // Memory contents: fixed word at 0x100, hashed pattern elsewhere.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h2408_0001;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign rd1 = mem_f(o1_addr);
  assign rd3 = mem_f(o3_addr);

  mem_bus_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(LIM)) u1 (
    .clk(clk), .rst(rst),
    .inst_read_i(ir), .inst_addr_i(ia), .inst_data_o(o1_idata), .inst_stall_o(o1_istall),
    .data_read_i(dr), .data_write_i(dw), .data_addr_i(da), .data_wdata_i(dwd),
    .data_mask_i(dm), .data_rdata_o(o1_ddata), .data_stall_o(o1_dstall),
    .mem_ce_o(o1_ce), .mem_we_o(o1_we), .mem_addr_o(o1_addr), .mem_wdata_o(o1_wdata),
    .mem_sel_o(o1_sel), .mem_rdata_i(rd1)
  );

  mem_bus_arbiter #(.WAIT_CYCLES(3), .STARVE_LIMIT(LIM)) u3 (
    .clk(clk), .rst(rst),
    .inst_read_i(ir), .inst_addr_i(ia), .inst_data_o(o3_idata), .inst_stall_o(o3_istall),
    .data_read_i(dr), .data_write_i(dw), .data_addr_i(da), .data_wdata_i(dwd),
    .data_mask_i(dm), .data_rdata_o(o3_ddata), .data_stall_o(o3_dstall),
    .mem_ce_o(o3_ce), .mem_we_o(o3_we), .mem_addr_o(o3_addr), .mem_wdata_o(o3_wdata),
    .mem_sel_o(o3_sel), .mem_rdata_i(rd3)
  );

  assign ob_idata  = (sel != 0) ? o3_idata  : o1_idata;
  assign ob_ddata  = (sel != 0) ? o3_ddata  : o1_ddata;
  assign ob_addr   = (sel != 0) ? o3_addr   : o1_addr;
  assign ob_wdata  = (sel != 0) ? o3_wdata  : o1_wdata;
  assign ob_istall = (sel != 0) ? o3_istall : o1_istall;
  assign ob_dstall = (sel != 0) ? o3_dstall : o1_dstall;
  assign ob_ce     = (sel != 0) ? o3_ce     : o1_ce;
  assign ob_we     = (sel != 0) ? o3_we     : o1_we;
  assign ob_sel    = (sel != 0) ? o3_sel    : o1_sel;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ir = 1'b0; ia = '0; dr = 1'b0; dw = 1'b0; da = '0; dwd = '0; dm = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_vec++;
    if ({o1_ce, o1_we, o1_addr, o1_wdata, o1_sel, o1_idata, o1_ddata, o1_istall, o1_dstall} !== '0) begin
      n_err++;
      $display("FAIL reset_u1: ce=%b we=%b addr=%h wdata=%h sel=%h idata=%h ddata=%h, required all 0",
               o1_ce, o1_we, o1_addr, o1_wdata, o1_sel, o1_idata, o1_ddata);
    end
    n_vec++;
    if ({o3_ce, o3_we, o3_addr, o3_wdata, o3_sel, o3_idata, o3_ddata, o3_istall, o3_dstall} !== '0) begin
      n_err++;
      $display("FAIL reset_u3: ce=%b we=%b addr=%h wdata=%h sel=%h idata=%h ddata=%h, required all 0",
               o3_ce, o3_we, o3_addr, o3_wdata, o3_sel, o3_idata, o3_ddata);
    end
  endtask

  task automatic test_fetch_single();
    sel = 0;
    do_reset();
    ir = 1'b1; ia = 32'h0000_0100;
    @(negedge clk);
    n_vec++;
    if ({ob_ce, ob_istall} !== 2'b01) begin
      n_err++; $display("FAIL fetch_c0: ce,istall=%b required 01", {ob_ce, ob_istall});
    end
    tick(); @(negedge clk);
    n_vec++;
    if ({ob_ce, ob_we, ob_sel, ob_addr, ob_istall} !== {1'b1, 1'b0, 4'hF, 32'h0000_0100, 1'b1}) begin
      n_err++; $display("FAIL fetch_c1: ce=%b we=%b sel=%h addr=%h istall=%b required 1 0 f 00000100 1",
                        ob_ce, ob_we, ob_sel, ob_addr, ob_istall);
    end
    tick(); @(negedge clk);
    n_vec++;
    if ({ob_ce, ob_istall, ob_idata} !== {1'b0, 1'b0, 32'h2408_0001}) begin
      n_err++; $display("FAIL fetch_c2: ce=%b istall=%b idata=%h required 0 0 24080001",
                        ob_ce, ob_istall, ob_idata);
    end
    tick();
    ir = 1'b0;
  endtask

  task automatic test_priority();
    sel = 0;
    do_reset();
    ir = 1'b1; ia = 32'h0000_0100;
    dr = 1'b1; da = 32'h0000_0200; dm = 4'b0101;
    @(negedge clk);
    n_vec++;
    if ({ob_istall, ob_dstall} !== 2'b11) begin
      n_err++; $display("FAIL prio_c0: istall,dstall=%b required 11", {ob_istall, ob_dstall});
    end
    tick(); @(negedge clk);
    n_vec++;
    if ({ob_ce, ob_we, ob_sel, ob_addr} !== {1'b1, 1'b0, 4'b0101, 32'h0000_0200}) begin
      n_err++; $display("FAIL prio_c1: ce=%b we=%b sel=%h addr=%h required 1 0 5 00000200",
                        ob_ce, ob_we, ob_sel, ob_addr);
    end
    tick(); @(negedge clk);
    n_vec++;
    if ({ob_istall, ob_dstall, ob_ddata} !== {1'b1, 1'b0, mem_f(32'h0000_0200)}) begin
      n_err++; $display("FAIL prio_c2: istall=%b dstall=%b ddata=%h required 1 0 %h",
                        ob_istall, ob_dstall, ob_ddata, mem_f(32'h0000_0200));
    end
    tick(); dr = 1'b0;
    tick(); @(negedge clk);
    n_vec++;
    if ({ob_ce, ob_sel, ob_addr, ob_istall} !== {1'b1, 4'hF, 32'h0000_0100, 1'b1}) begin
      n_err++; $display("FAIL prio_c4: ce=%b sel=%h addr=%h istall=%b required 1 f 00000100 1",
                        ob_ce, ob_sel, ob_addr, ob_istall);
    end
    tick(); @(negedge clk);
    n_vec++;
    if ({ob_istall, ob_idata, ob_ddata} !== {1'b0, 32'h2408_0001, mem_f(32'h0000_0200)}) begin
      n_err++; $display("FAIL prio_c5: istall=%b idata=%h ddata=%h required 0 24080001 %h",
                        ob_istall, ob_idata, ob_ddata, mem_f(32'h0000_0200));
    end
    tick();
    ir = 1'b0;
  endtask

  task automatic test_starvation();
    logic exp_i;
    sel = 0;
    do_reset();
    ir = 1'b1; ia = 32'h0000_0100;
    dr = 1'b1; da = 32'h0000_0300; dm = 4'hF;
    for (int k = 0; k < 15; k++) begin
      tick(); tick(); @(negedge clk);
      exp_i = ((k % 5) == 4);
      n_vec++;
      if ({ob_istall, ob_dstall} !== {~exp_i, exp_i}) begin
        n_err++; $display("FAIL starve_grant%0d: istall,dstall=%b required %b",
                          k, {ob_istall, ob_dstall}, {~exp_i, exp_i});
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_write();
    sel = 1;
    do_reset();
    dr = 1'b1; da = 32'h0000_0440; dm = 4'hF;
    repeat (4) tick();
    @(negedge clk);
    n_vec++;
    if ({ob_dstall, ob_ddata} !== {1'b0, mem_f(32'h0000_0440)}) begin
      n_err++; $display("FAIL wr_preread: dstall=%b ddata=%h required 0 %h",
                        ob_dstall, ob_ddata, mem_f(32'h0000_0440));
    end
    tick();
    dr = 1'b1; dw = 1'b1; da = 32'h8000_0010; dm = 4'b0011; dwd = 32'hDEAD_BEEF;
    for (int j = 1; j <= 3; j++) begin
      tick(); @(negedge clk);
      n_vec++;
      if ({ob_ce, ob_we, ob_sel, ob_addr, ob_wdata, ob_dstall, ob_ddata} !==
          {1'b1, 1'b1, 4'b0011, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, mem_f(32'h0000_0440)}) begin
        n_err++; $display("FAIL wr_c%0d: ce=%b we=%b sel=%h addr=%h wdata=%h dstall=%b ddata=%h required 1 1 3 80000010 deadbeef 1 %h",
                          j, ob_ce, ob_we, ob_sel, ob_addr, ob_wdata, ob_dstall, ob_ddata, mem_f(32'h0000_0440));
      end
    end
    tick(); @(negedge clk);
    n_vec++;
    if ({ob_ce, ob_we, ob_dstall, ob_ddata} !== {1'b0, 1'b0, 1'b0, mem_f(32'h0000_0440)}) begin
      n_err++; $display("FAIL wr_done: ce=%b we=%b dstall=%b ddata=%h required 0 0 0 %h",
                        ob_ce, ob_we, ob_dstall, ob_ddata, mem_f(32'h0000_0440));
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_addr_latch();
    sel = 1;
    do_reset();
    dr = 1'b1; da = 32'h0000_1234; dm = 4'hF;
    @(negedge clk);
    n_vec++;
    if (ob_dstall !== 1'b1) begin
      n_err++; $display("FAIL latch_c0: dstall=%b required 1", ob_dstall);
    end
    for (int j = 1; j <= 3; j++) begin
      tick();
      da = $urandom;
      @(negedge clk);
      n_vec++;
      if ({ob_ce, ob_addr, ob_dstall} !== {1'b1, 32'h0000_1234, 1'b1}) begin
        n_err++; $display("FAIL latch_c%0d: ce=%b addr=%h dstall=%b required 1 00001234 1",
                          j, ob_ce, ob_addr, ob_dstall);
      end
    end
    tick(); @(negedge clk);
    n_vec++;
    if ({ob_dstall, ob_ddata} !== {1'b0, mem_f(32'h0000_1234)}) begin
      n_err++; $display("FAIL latch_c4: dstall=%b ddata=%h required 0 %h",
                        ob_dstall, ob_ddata, mem_f(32'h0000_1234));
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_access();
    sel = 1;
    do_reset();
    ir = 1'b1; ia = 32'h0000_0500;
    tick(); tick(); @(negedge clk);
    n_vec++;
    if (ob_ce !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: ce=%b required 1", ob_ce);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({ob_ce, ob_we} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_async: ce,we=%b required 00", {ob_ce, ob_we});
    end
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({ob_ce, ob_istall} !== 2'b01) begin
      n_err++; $display("FAIL rstmid_c0: ce,istall=%b required 01", {ob_ce, ob_istall});
    end
    tick(); @(negedge clk);
    n_vec++;
    if ({ob_ce, ob_addr} !== {1'b1, 32'h0000_0500}) begin
      n_err++; $display("FAIL rstmid_c1: ce=%b addr=%h required 1 00000500", ob_ce, ob_addr);
    end
    tick(); tick(); tick(); @(negedge clk);
    n_vec++;
    if ({ob_istall, ob_idata} !== {1'b0, mem_f(32'h0000_0500)}) begin
      n_err++; $display("FAIL rstmid_c4: istall=%b idata=%h required 0 %h",
                        ob_istall, ob_idata, mem_f(32'h0000_0500));
    end
    tick();
    idle_inputs();
  endtask

  // Randomized traffic; the model tracks the last grant's cycle and derives
  // the access window, completion cycle and next free cycle from it.
  task automatic test_random(input int s, input int ncyc);
    int          w;
    int          gc;
    int          starve;
    logic        gd, gw, in_acc, in_done, idle, pdone_i, pdone_d, dreq;
    logic [31:0] ga, gwd, e_inst, e_data;
    logic [3:0]  gs;
    logic [1:0]  t;
    sel = s;
    w = (s != 0) ? 3 : 1;
    gc = -1000; starve = 0;
    gd = 1'b0; gw = 1'b0; ga = '0; gwd = '0; gs = '0;
    e_inst = '0; e_data = '0;
    pdone_i = 1'b0; pdone_d = 1'b0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      if (c == 0 || pdone_i || $urandom_range(15) == 0) begin
        ir = ($urandom_range(3) != 0);
        ia = $urandom;
      end
      if (c == 0 || pdone_d || $urandom_range(15) == 0) begin
        t = 2'($urandom_range(3));
        dr = t[0]; dw = t[1];
        da = $urandom; dwd = $urandom; dm = 4'($urandom);
      end
      @(negedge clk);
      in_acc  = (c >= gc + 1) && (c <= gc + w);
      in_done = (c == gc + w + 1);
      idle    = (c >= gc + w + 2);
      if (in_done && !gw) begin
        if (gd) e_data = mem_f(ga);
        else    e_inst = mem_f(ga);
      end
      n_vec++;
      if ({ob_ce, ob_we} !== {in_acc, in_acc & gw}) begin
        n_err++; $display("FAIL rnd%0d_cewe c=%0d: ce,we=%b required %b", s, c, {ob_ce, ob_we}, {in_acc, in_acc & gw});
      end
      if (in_acc) begin
        n_vec++;
        if ({ob_addr, ob_sel} !== {ga, gs} || (gw && ob_wdata !== gwd)) begin
          n_err++; $display("FAIL rnd%0d_bus c=%0d: addr=%h sel=%h wdata=%h required %h %h %h",
                            s, c, ob_addr, ob_sel, ob_wdata, ga, gs, gwd);
        end
      end
      n_vec++;
      if ({ob_istall, ob_dstall} !== {ir & ~(in_done & ~gd), (dr | dw) & ~(in_done & gd)}) begin
        n_err++; $display("FAIL rnd%0d_stall c=%0d: istall,dstall=%b required %b", s, c,
                          {ob_istall, ob_dstall}, {ir & ~(in_done & ~gd), (dr | dw) & ~(in_done & gd)});
      end
      n_vec++;
      if ({ob_idata, ob_ddata} !== {e_inst, e_data}) begin
        n_err++; $display("FAIL rnd%0d_rdata c=%0d: idata=%h ddata=%h required %h %h",
                          s, c, ob_idata, ob_ddata, e_inst, e_data);
      end
      pdone_i = in_done && !gd;
      pdone_d = in_done && gd;
      dreq = dr | dw;
      if (idle) begin
        if (dreq && !(ir && starve == LIM)) begin
          gd = 1'b1; gw = dw; ga = da; gwd = dwd; gs = dm; gc = c;
          starve = ir ? ((starve < LIM) ? starve + 1 : LIM) : 0;
        end else if (ir) begin
          gd = 1'b0; gw = 1'b0; ga = ia; gs = 4'hF; gc = c;
          starve = 0;
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch_single();
    test_priority();
    test_starvation();
    test_write();
    test_addr_latch();
    test_reset_mid_access();
    test_random(0, 400);
    test_random(1, 400);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
